cas_recorder: RTL and testbench

//  Cassette tape recorder: the write-side counterpart of the tape playback path.

---
 rtl/cas_recorder.sv | 159 +++++++++++++++
 tb/tb_cas_recorder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cas_recorder.sv
// Cassette recorder: samples the machine's cassette output at the tape bit rate,
// packs 8 samples per byte (MSB first) and writes the bytes into tape RAM.
module cas_recorder #(
   parameter int ADDR_W = 15,
   parameter int DIV    = 6667
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              cas_in,
   input  logic              rec_start,
   input  logic              rec_stop,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic [ADDR_W:0]   rec_len,
   output logic              busy,
   output logic              full
);

   // state  | meaning
   // IDLE   | no take in progress; rec_len holds the last take's length
   // ARM    | take armed, waiting for the first edge on cas_s (skips silence)
   // RECORD | sampling at the tick rate, writing each completed byte
   // FULL   | tape RAM exhausted; no further writes until re-armed
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARM    = 2'd1,
      S_RECORD = 2'd2,
      S_FULL   = 2'd3
   } state_t;

   localparam int                DIV_W    = $clog2(DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   CAP      = {1'b1, {ADDR_W{1'b0}}};

   state_t              state_q;
   logic                cas_meta_q;
   logic                cas_s_q;
   logic                cas_s_d1_q;
   logic [DIV_W-1:0]    div_q;
   logic [3:0]          bitcnt_q;
   logic [7:0]          shreg_q;
   logic [ADDR_W:0]     rec_len_q;
   logic                ram_we_q;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic [7:0]          ram_data_q;

   logic                tick;
   logic                cas_edge;
   logic [7:0]          shreg_d;
   logic [3:0]          bitcnt_d;
   logic [7:0]          flush_data;
   logic                arm_req;

   // A tick that coincides with rec_stop is folded in before the flush byte is formed.
   always_comb begin
      tick       = (state_q == S_RECORD) && (div_q == '0);
      cas_edge   = cas_s_q ^ cas_s_d1_q;
      shreg_d    = tick ? {shreg_q[6:0], cas_s_q} : shreg_q;
      bitcnt_d   = tick ? (bitcnt_q + 4'd1) : bitcnt_q;
      flush_data = shreg_d << (4'd8 - bitcnt_d);
      arm_req    = rec_start && !rec_stop;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cas_meta_q <= 1'b0;
         cas_s_q    <= 1'b0;
         cas_s_d1_q <= 1'b0;
         div_q      <= '0;
         bitcnt_q   <= '0;
         shreg_q    <= '0;
         rec_len_q  <= '0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
      end else begin
         cas_meta_q <= cas_in;
         cas_s_q    <= cas_meta_q;
         cas_s_d1_q <= cas_s_q;
         ram_we_q   <= 1'b0;

         // Commit the byte written last cycle; rec_len doubles as the write pointer.
         if (ram_we_q && (rec_len_q != CAP)) begin
            rec_len_q <= rec_len_q + LEN_ONE;
         end

         case (state_q)
            S_IDLE: begin
               if (arm_req) begin
                  state_q   <= S_ARM;
                  rec_len_q <= '0;
                  bitcnt_q  <= '0;
                  div_q     <= '0;
                  shreg_q   <= '0;
               end
            end

            S_ARM: begin
               if (rec_stop) begin
                  state_q <= S_IDLE;
               end else if (cas_edge) begin
                  state_q <= S_RECORD;
                  div_q   <= '0;
               end
            end

            S_RECORD: begin
               div_q    <= (div_q == DIV_LAST) ? '0 : (div_q + DIV_ONE);
               shreg_q  <= shreg_d;
               bitcnt_q <= bitcnt_d;
               if (rec_stop) begin
                  state_q  <= S_IDLE;
                  bitcnt_q <= '0;
                  shreg_q  <= '0;
                  if (bitcnt_d != 4'd0) begin
                     ram_we_q   <= 1'b1;
                     ram_addr_q <= rec_len_q[ADDR_W-1:0];
                     ram_data_q <= flush_data;
                  end
               end else begin
                  if (bitcnt_d == 4'd8) begin
                     bitcnt_q   <= '0;
                     ram_we_q   <= 1'b1;
                     ram_addr_q <= rec_len_q[ADDR_W-1:0];
                     ram_data_q <= shreg_d;
                  end
                  if (ram_we_q && ((rec_len_q + LEN_ONE) == CAP)) begin
                     state_q <= S_FULL;
                  end
               end
            end

            S_FULL: begin
               if (arm_req) begin
                  state_q   <= S_ARM;
                  rec_len_q <= '0;
                  bitcnt_q  <= '0;
                  div_q     <= '0;
                  shreg_q   <= '0;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign rec_len  = rec_len_q;
   assign busy     = (state_q == S_ARM) || (state_q == S_RECORD);
   assign full     = (state_q == S_FULL);

endmodule

// File: tb/tb_cas_recorder.sv
// Bench for cas_recorder (ADDR_W=3, DIV=4): directed stimulus, expected writes
// queued up front and checked by an independent monitor on every ram_we.
module tb_cas_recorder;

   localparam int ADDR_W = 3;
   localparam int DIV    = 4;

   logic              clk_sys = 1'b0;
   logic              reset_n;
   logic              cas_in;
   logic              rec_start;
   logic              rec_stop;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_data;
   logic [ADDR_W:0]   rec_len;
   logic              busy;
   logic              full;

   int total = 0;
   int bad   = 0;
   logic [ADDR_W+7:0] exp_q[$];
   logic prev_we = 1'b0;

   cas_recorder #(.ADDR_W(ADDR_W), .DIV(DIV)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .cas_in    (cas_in),
      .rec_start (rec_start),
      .rec_stop  (rec_stop),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .rec_len   (rec_len),
      .busy      (busy),
      .full      (full)
   );

   always #5 clk_sys = ~clk_sys;

   // Monitor: every write must match the head of the expected-write queue.
   always @(negedge clk_sys) begin
      logic [ADDR_W+7:0] e;
      if (ram_we) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", ram_addr, ram_data);
         end else begin
            e = exp_q.pop_front();
            if ({ram_addr, ram_data} !== e) begin
               bad++;
               $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        ram_addr, ram_data, e[ADDR_W+7:8], e[7:0]);
            end
         end
      end
      if (ram_we && prev_we) begin
         bad++;
         $display("FAIL back_to_back_we: ram_we high on two consecutive cycles");
      end
      if (rec_len > 4'd8) begin
         bad++;
         $display("FAIL rec_len_range: got %0d, required <= 8", rec_len);
      end
      prev_we = ram_we;
   end

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic pulse_start();
      rec_start = 1'b1;
      cyc(1);
      rec_start = 1'b0;
   endtask

   task automatic pulse_stop();
      rec_stop = 1'b1;
      cyc(1);
      rec_stop = 1'b0;
   endtask

   // One tape sample, held for DIV cycles.
   task automatic send(input logic b);
      cas_in = b;
      cyc(DIV);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send(b[i]);
   endtask

   task automatic expect_write(input int addr, input logic [7:0] data);
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(addr);
      exp_q.push_back({a, data});
   endtask

   initial begin
      reset_n   = 1'b0;
      cas_in    = 1'b0;
      rec_start = 1'b0;
      rec_stop  = 1'b0;
      cyc(3);
      chk("reset_ram_we", int'(ram_we), 0);
      chk("reset_ram_addr", int'(ram_addr), 0);
      chk("reset_ram_data", int'(ram_data), 0);
      chk("reset_rec_len", int'(rec_len), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_full", int'(full), 0);
      reset_n = 1'b1;
      cyc(5);

      // 1: armed with silent input stays in ARM and writes nothing.
      pulse_start();
      cyc(100);
      chk("t1_busy", int'(busy), 1);
      chk("t1_full", int'(full), 0);
      chk("t1_rec_len", int'(rec_len), 0);
      pulse_stop();
      chk("t1_idle_busy", int'(busy), 0);
      cyc(5);

      // 2: one full byte 1011_0010, stop before the next tick.
      pulse_start();
      expect_write(0, 8'hB2);
      send_byte(8'hB2);
      pulse_stop();
      cyc(3);
      chk("t2_rec_len", int'(rec_len), 1);
      chk("t2_busy", int'(busy), 0);
      cyc(10);

      // 3: three samples 1,1,0 then stop -> flushed left-aligned 0xC0.
      pulse_start();
      chk("t3_arm_rec_len", int'(rec_len), 0);
      expect_write(0, 8'hC0);
      send(1'b1);
      send(1'b1);
      send(1'b0);
      pulse_stop();
      cyc(3);
      chk("t3_rec_len", int'(rec_len), 1);
      chk("t3_busy", int'(busy), 0);
      cyc(10);

      // 4: 64 alternating samples fill the 8-byte tape; extra samples write nothing.
      pulse_start();
      for (int i = 0; i < 8; i++) expect_write(i, 8'hAA);
      for (int i = 0; i < 8; i++) send_byte(8'hAA);
      cyc(2);
      for (int i = 0; i < 8; i++) send(i[0] ? 1'b0 : 1'b1);
      chk("t4_full", int'(full), 1);
      chk("t4_rec_len", int'(rec_len), 8);
      chk("t4_busy", int'(busy), 0);
      cyc(5);

      // 5: re-arm from FULL; new take starts at address 0.
      pulse_start();
      chk("t5_busy", int'(busy), 1);
      chk("t5_full", int'(full), 0);
      chk("t5_rec_len", int'(rec_len), 0);
      expect_write(0, 8'h96);
      send_byte(8'h96);
      pulse_stop();
      cyc(3);
      chk("t5_rec_len_after", int'(rec_len), 1);
      cyc(10);

      // 6: reset mid-byte clears outputs at once and writes nothing further.
      pulse_start();
      expect_write(0, 8'hC3);
      send_byte(8'hC3);
      send(1'b1);
      send(1'b0);
      send(1'b1);
      chk("t6_pre_rec_len", int'(rec_len), 1);
      #2;
      reset_n = 1'b0;
      cas_in  = 1'b0;
      #1;
      chk("t6_rst_ram_addr", int'(ram_addr), 0);
      chk("t6_rst_ram_data", int'(ram_data), 0);
      chk("t6_rst_rec_len", int'(rec_len), 0);
      chk("t6_rst_busy", int'(busy), 0);
      cyc(3);
      reset_n = 1'b1;
      cyc(40);
      chk("t6_post_busy", int'(busy), 0);
      chk("t6_post_rec_len", int'(rec_len), 0);

      rec_start = 1'b1;
      rec_stop  = 1'b1;
      cyc(1);
      rec_start = 1'b0;
      rec_stop  = 1'b0;
      cyc(3);
      chk("t6_start_stop_busy", int'(busy), 0);
      cyc(20);

      chk("writes_outstanding", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
